// File: rtl/dcache_nway.sv
// N-way (1 or 2) write-back, write-allocate data cache with a single-line memory port.
// One request at a time: misses stall the CPU through write-back, allocate and fill.

module dcache_way #(
    parameter int SET_BITS = 4,
    parameter int LINE_W   = 256,
    parameter int TAG_W    = 23
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [SET_BITS-1:0] idx_i,
    input  logic [TAG_W-1:0]    tag_i,
    input  logic [2:0]          word_i,
    input  logic [31:0]         wdata_i,
    input  logic                wr_hit_i,
    input  logic                fill_i,
    input  logic [LINE_W-1:0]   fill_line_i,
    output logic                hit_o,
    output logic                valid_o,
    output logic                dirty_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic [LINE_W-1:0]   line_o
);
    localparam int SETS = 1 << SET_BITS;

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];
    assign hit_o   = valid_o && (tag_o == tag_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (wr_hit_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag/data storage survives reset; only the write enables are suppressed.
    always_ff @(posedge clk_i) begin
        if (!rst_i && fill_i) begin
            tag_q[idx_i]  <= tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (!rst_i && wr_hit_i) begin
            data_q[idx_i][32*word_i +: 32] <= wdata_i;
        end
    end
endmodule

module dcache_nway #(
    parameter int SET_BITS = 4,
    parameter int WAYS     = 2,
    parameter int LINE_W   = 256,
    parameter int ADDR_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);
    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = ADDR_W - 5 - SET_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE, S_FILL} state_e;

    state_e state_q, state_d;

    logic [2:0]          word;
    logic [SET_BITS-1:0] idx;
    logic [TAG_W-1:0]    tag;
    logic                req, wr, rd;

    assign word = p1_addr_i[4:2];
    assign idx  = p1_addr_i[4+SET_BITS:5];
    assign tag  = p1_addr_i[ADDR_W-1:5+SET_BITS];
    assign req  = p1_MemRead_i | p1_MemWrite_i;
    assign wr   = p1_MemWrite_i;
    assign rd   = p1_MemRead_i & ~p1_MemWrite_i;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^p1_addr_i[1:0];

    logic [WAYS-1:0]              way_hit, way_valid, way_dirty, way_fill, way_wr;
    logic [WAYS-1:0][TAG_W-1:0]   way_tag;
    logic [WAYS-1:0][LINE_W-1:0]  way_line;

    logic              victim_q, victim_d;
    logic [SETS-1:0]   lru_q;
    logic [LINE_W-1:0] line_q;
    logic              hit, hit_way;
    logic [LINE_W-1:0] hit_line;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_fill[w] = (state_q == S_FILL) && (victim_q == 1'(w));
        assign way_wr[w]   = (state_q == S_IDLE) && wr && way_hit[w];

        dcache_way #(
            .SET_BITS (SET_BITS),
            .LINE_W   (LINE_W),
            .TAG_W    (TAG_W)
        ) u_way (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .idx_i       (idx),
            .tag_i       (tag),
            .word_i      (word),
            .wdata_i     (p1_data_i),
            .wr_hit_i    (way_wr[w]),
            .fill_i      (way_fill[w]),
            .fill_line_i (line_q),
            .hit_o       (way_hit[w]),
            .valid_o     (way_valid[w]),
            .dirty_o     (way_dirty[w]),
            .tag_o       (way_tag[w]),
            .line_o      (way_line[w])
        );
    end

    assign hit = |way_hit;

    always_comb begin
        hit_line = '0;
        hit_way  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                hit_line = way_line[w];
                hit_way  = 1'(w);
            end
        end
    end

    // Invalid ways fill first (way 0 preferred); a full set evicts its LRU way.
    always_comb begin
        victim_d = 1'b0;
        if (WAYS == 2 && way_valid[0])
            victim_d = way_valid[WAYS-1] ? lru_q[idx] : 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lru_q    <= '0;
            victim_q <= 1'b0;
        end else if (state_q == S_IDLE && req) begin
            if (hit && WAYS == 2)
                lru_q[idx] <= ~hit_way;
            if (!hit)
                victim_q <= victim_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == S_ALLOCATE && mem_ack_i)
            line_q <= mem_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req && !hit)
                    state_d = (way_valid[victim_d] && way_dirty[victim_d]) ? S_WRITEBACK : S_ALLOCATE;
            end
            S_WRITEBACK: if (mem_ack_i) state_d = S_ALLOCATE;
            S_ALLOCATE:  if (mem_ack_i) state_d = S_FILL;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        p1_stall_o   = 1'b1;
        p1_data_o    = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_q)
            S_IDLE: begin
                p1_stall_o = req & ~hit;
                if (rd && hit)
                    p1_data_o = hit_line[32*word +: 32];
            end
            S_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {way_tag[victim_q], idx, 5'b0};
                mem_data_o   = way_line[victim_q];
            end
            S_ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, idx, 5'b0};
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dcache_nway.sv
// Random load/store traffic against a transaction-level cache and memory model,
// plus directed eviction, LRU, mid-miss reset and direct-mapped scenarios.

module tb_dcache_nway;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  addr = '0, wdata = '0;
    logic         rd = 1'b0, wr = 1'b0;
    logic [31:0]  p1_data;
    logic         stall;
    logic [255:0] mem_rdata = '0;
    logic         ack = 1'b0;
    logic [255:0] mem_wdata;
    logic [31:0]  mem_addr;
    logic         mem_en, mem_we;

    logic [31:0]  addr1 = '0;
    logic         rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0]  p1_data1;
    logic         stall1;
    logic [255:0] mem_rdata1 = '0;
    logic         ack1 = 1'b0;
    logic [255:0] mem_wdata1_unused;
    logic [31:0]  mem_addr1;
    logic         mem_en1, mem_we1;

    always #5 clk = ~clk;

    dcache_nway u_dut (
        .clk_i(clk), .rst_i(rst), .p1_addr_i(addr), .p1_data_i(wdata),
        .p1_MemRead_i(rd), .p1_MemWrite_i(wr), .p1_data_o(p1_data), .p1_stall_o(stall),
        .mem_data_i(mem_rdata), .mem_ack_i(ack), .mem_data_o(mem_wdata),
        .mem_addr_o(mem_addr), .mem_enable_o(mem_en), .mem_write_o(mem_we)
    );

    dcache_nway #(.WAYS(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .p1_addr_i(addr1), .p1_data_i(wdata),
        .p1_MemRead_i(rd1), .p1_MemWrite_i(wr1), .p1_data_o(p1_data1), .p1_stall_o(stall1),
        .mem_data_i(mem_rdata1), .mem_ack_i(ack1), .mem_data_o(mem_wdata1_unused),
        .mem_addr_o(mem_addr1), .mem_enable_o(mem_en1), .mem_write_o(mem_we1)
    );

    int nvec = 0, nerr = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Backing memory (line granularity) and the architectural word view the CPU should see.
    logic [255:0] bmem [logic [31:0]];
    logic [31:0]  arch [logic [31:0]];
    logic [31:0]  res  [16][$];          // resident line addresses per set, MRU first
    bit           dirtyl [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E3779B1) ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [255:0] init_line(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = init_word(la + 32'(4*k));
        return l;
    endfunction

    function automatic logic [255:0] back_line(input logic [31:0] la);
        if (bmem.exists(la)) return bmem[la];
        return init_line(la);
    endfunction

    function automatic logic [31:0] arch_word(input logic [31:0] wa);
        logic [255:0] l;
        if (arch.exists(wa)) return arch[wa];
        l = back_line(wa & ~32'h1f);
        return l[32*wa[4:2] +: 32];
    endfunction

    function automatic logic [255:0] arch_line(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = arch_word(la + 32'(4*k));
        return l;
    endfunction

    // Memory responder: acks after lat enabled cycles, records every transfer.
    int           lat = 1, cnt = 0;
    bit           resp_on = 1'b1;
    bit           obs_we   [$];
    logic [31:0]  obs_addr [$];
    logic [255:0] obs_data [$];

    always @(negedge clk) begin
        if (!resp_on) cnt = 0;
        else if (ack) ack = 1'b0;
        else if (mem_en) begin
            cnt++;
            if (cnt >= lat) begin
                obs_we.push_back(mem_we);
                obs_addr.push_back(mem_addr);
                obs_data.push_back(mem_we ? mem_wdata : 256'h0);
                if (mem_we) bmem[mem_addr] = mem_wdata;
                else        mem_rdata = back_line(mem_addr);
                ack = 1'b1;
                cnt = 0;
            end
        end else cnt = 0;
    end

    always @(negedge clk) begin
        if (ack1) ack1 = 1'b0;
        else if (mem_en1) begin
            mem_rdata1 = init_line(mem_addr1);
            ack1 = 1'b1;
        end
    end

    task automatic model_reset();
        for (int s = 0; s < 16; s++) res[s].delete();
        dirtyl.delete();
        arch.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rd = 1'b0; wr = 1'b0; rd1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_stall", stall, 1'b0);
        chk("rst_en", mem_en, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_data", p1_data, 32'h0);
    endtask

    task automatic acc(input logic [31:0] a, input bit r, input bit w, input logic [31:0] d);
        logic [31:0]  la, wa, vic;
        logic [255:0] vline;
        logic [3:0]   set;
        bit           hit_exp, wb_exp, evict;
        int           n, k;
        la = a & ~32'h1f; wa = a & ~32'h3; set = a[8:5];
        hit_exp = 1'b0;
        foreach (res[set][i]) if (res[set][i] == la) hit_exp = 1'b1;
        @(negedge clk);
        addr = a; rd = r; wr = w; wdata = d;
        obs_we.delete(); obs_addr.delete(); obs_data.delete();
        #1;
        chk("stall", stall, !hit_exp);
        if (!hit_exp) begin
            evict  = (res[set].size() == 2);
            vic    = evict ? res[set][$] : 32'h0;
            wb_exp = evict && dirtyl.exists(vic);
            vline  = arch_line(vic);
            n = 1;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk); #1;
                if (!stall) break;
                n++;
            end
            chk("miss_done", stall, 1'b0);
            chk("miss_cycles", n >= lat + 2 + (wb_exp ? lat + 1 : 0), 1'b1);
            chk("xfers", obs_addr.size(), wb_exp ? 2 : 1);
            k = obs_addr.size();
            if (wb_exp && k == 2) begin
                chk("wb_we", obs_we[0], 1'b1);
                chk("wb_addr", obs_addr[0], vic);
                chk("wb_data", obs_data[0], vline);
            end
            if (k > 0) begin
                chk("al_we", obs_we[k-1], 1'b0);
                chk("al_addr", obs_addr[k-1], la);
            end
            if (evict) begin
                void'(res[set].pop_back());
                dirtyl.delete(vic);
            end
        end else begin
            foreach (res[set][i]) if (res[set][i] == la) begin res[set].delete(i); break; end
        end
        res[set].push_front(la);
        if (r && !w) chk("rdata", p1_data, arch_word(wa));
        if (w) begin
            arch[wa] = d;
            dirtyl[la] = 1'b1;
        end
    endtask

    task automatic acc1(input logic [31:0] a, input bit hit_exp);
        @(negedge clk);
        addr1 = a; rd1 = 1'b1;
        #1;
        chk("w1_stall", stall1, !hit_exp);
        for (int i = 0; i < 50; i++) begin
            if (!stall1) break;
            chk("w1_we", mem_we1, 1'b0);
            @(negedge clk); #1;
        end
        chk("w1_done", stall1, 1'b0);
        chk("w1_rdata", p1_data1, init_word(a & ~32'h3));
        @(negedge clk);
        rd1 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          op;
        model_reset();
        repeat (3) @(negedge clk);
        do_reset();

        // Cold miss, write hit, two dirty lines in set 0, then a dirty eviction.
        lat = 1;
        acc(32'h000, 1, 0, 0);
        acc(32'h004, 0, 1, 32'hDEADBEEF);
        acc(32'h004, 1, 0, 0);
        acc(32'h200, 1, 0, 0);
        acc(32'h204, 0, 1, 32'h1234_5678);
        acc(32'h400, 1, 0, 0);
        if (obs_data.size() == 2) chk("wb_word1", obs_data[0][63:32], 32'hDEADBEEF);
        else chk("wb_seen", obs_data.size(), 2);

        // Clean LRU order: 0x200 is least recent when 0x400 arrives.
        do_reset();
        lat = 2;
        acc(32'h000, 1, 0, 0);
        acc(32'h200, 1, 0, 0);
        acc(32'h000, 1, 0, 0);
        acc(32'h400, 1, 0, 0);
        if (obs_addr.size() == 1) chk("lru_no_wb", obs_we[0], 1'b0);
        else chk("lru_xfers", obs_addr.size(), 1);
        acc(32'h000, 1, 0, 0);

        for (int it = 0; it < 400; it++) begin
            lat = $urandom_range(1, 3);
            op  = $urandom_range(0, 3);
            a   = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5)
                | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            acc(a, op != 2, op >= 2, $urandom);
        end

        // Reset during an allocate, then a late ack that must be ignored.
        do_reset();
        resp_on = 1'b0;
        @(negedge clk);
        addr = 32'h600; rd = 1'b1; wr = 1'b0;
        #1 chk("mid_stall", stall, 1'b1);
        @(negedge clk); #1;
        chk("mid_en", mem_en, 1'b1);
        chk("mid_we", mem_we, 1'b0);
        chk("mid_addr", mem_addr, 32'h600);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("abort_en", mem_en, 1'b0);
        chk("abort_we", mem_we, 1'b0);
        chk("abort_stall", stall, 1'b1);
        chk("abort_data", p1_data, 32'h0);
        mem_rdata = 256'h0;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        #1;
        chk("reissue_en", mem_en, 1'b1);
        chk("reissue_addr", mem_addr, 32'h600);
        lat = 1;
        resp_on = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (!stall) break;
            @(negedge clk); #1;
        end
        chk("reissue_done", stall, 1'b0);
        chk("reissue_rdata", p1_data, arch_word(32'h600));
        res[0].push_front(32'h600);
        @(negedge clk);
        rd = 1'b0;

        // Direct-mapped instance: conflicting lines evict each other.
        do_reset();
        acc1(32'h000, 1'b0);
        acc1(32'h008, 1'b1);
        acc1(32'h20C, 1'b0);
        acc1(32'h000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
